// File: rtl/trivium_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// trivium_seq_ctrl_if
// Keystream word stream between the Trivium sequencer and its consumer.
//   out_data  [OUT_W]  keystream word, first generated bit in bit 0
//   out_valid          out_data valid, held until out_ready
//   out_ready          consumer accepts when out_valid && out_ready
// With TRIV_CIPHER_EN defined the interface also carries the plaintext side:
//   in_data   [OUT_W]  word to be combined with the keystream
//   in_valid           in_data available
//   in_ready           in_data consumed this cycle
// master: the sequencer; slave: the consumer/producer on the host side.
// ---------------------------------------------------------------------------
interface trivium_seq_ctrl_if #(
    parameter int OUT_W = 8
);
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
`ifdef TRIV_CIPHER_EN
    logic [OUT_W-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (
        output out_data, out_valid, in_ready,
        input  out_ready, in_data, in_valid
    );
    modport slave (
        input  out_data, out_valid, in_ready,
        output out_ready, in_data, in_valid
    );
`else
    modport master (
        output out_data, out_valid,
        input  out_ready
    );
    modport slave (
        input  out_data, out_valid,
        output out_ready
    );
`endif
endinterface

// File: rtl/trivium_seq_ctrl.sv
// ---------------------------------------------------------------------------
// trivium_seq_ctrl
// Sequencer for the Trivium keystream core: on start pulses core_load, runs
// WARMUP_CYCLES discarded steps, then steps the core to pack keystream bits
// LSB-first into OUT_W-bit words delivered on a valid/ready stream. The core
// is frozen while a finished word cannot be handed to the output register.
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   start, len      begin a session of len words (sampled in IDLE only)
//   abort           end the session immediately, no done pulse
//   busy            state other than IDLE
//   done            one-cycle pulse after the last word is accepted
//   core_load       one-cycle pulse: core loads key/IV
//   core_step       core advances one step this cycle
//   core_ks_bit     keystream bit of the current core state
//   strm            word stream (trivium_seq_ctrl_if.master)
// Optional feature: define TRIV_CIPHER_EN to XOR each keystream word with a
// word taken from strm.in_data (in_valid/in_ready handshake).
// ---------------------------------------------------------------------------
module trivium_seq_ctrl #(
    parameter int WARMUP_CYCLES = 1152,
    parameter int OUT_W         = 8,
    parameter int LEN_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             core_load,
    output logic             core_step,
    input  logic             core_ks_bit,
    trivium_seq_ctrl_if.master strm
);
    localparam int WC_W = $clog2(WARMUP_CYCLES + 1);
    localparam int BC_W = $clog2(OUT_W + 1);
    localparam logic [WC_W-1:0]  WARM_LAST = WC_W'(WARMUP_CYCLES - 1);
    localparam logic [BC_W-1:0]  BIT_LAST  = BC_W'(OUT_W - 1);
    localparam logic [BC_W-1:0]  BIT_FULL  = BC_W'(OUT_W);
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

    typedef enum logic [1:0] {IDLE, LOAD, WARMUP, RUN} state_t;

    state_t           state;
    logic [WC_W-1:0]  warm_cnt;
    logic [BC_W-1:0]  bit_cnt;       // bits in shifter; BIT_FULL = parked word
    logic [OUT_W-1:0] shifter;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] words_filled;  // words whose shifter fill has completed
    logic [LEN_W-1:0] words_done;    // words accepted by the consumer
    logic [OUT_W-1:0] out_data_q;
    logic             out_valid_q;

    logic             run_ok;
    logic             fill_done;
    logic             hs;
    logic [OUT_W-1:0] word_new;

`ifdef TRIV_CIPHER_EN
    assign run_ok   = strm.in_valid;
    assign word_new = {core_ks_bit, shifter[OUT_W-1:1]} ^ strm.in_data;
    assign strm.in_ready = fill_done;
`else
    assign run_ok   = 1'b1;
    assign word_new = {core_ks_bit, shifter[OUT_W-1:1]};
`endif

    assign busy      = (state != IDLE);
    assign hs        = out_valid_q && strm.out_ready;
    assign core_step = (state == WARMUP) ||
                       ((state == RUN) && (bit_cnt != BIT_FULL) &&
                        (words_filled < len_q) && run_ok);
    assign fill_done = (state == RUN) && core_step && (bit_cnt == BIT_LAST);

    assign strm.out_data  = out_data_q;
    assign strm.out_valid = out_valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            warm_cnt     <= '0;
            bit_cnt      <= '0;
            shifter      <= '0;
            len_q        <= '0;
            words_filled <= '0;
            words_done   <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            done         <= 1'b0;
            core_load    <= 1'b0;
        end else if (abort) begin
            state        <= IDLE;
            warm_cnt     <= '0;
            bit_cnt      <= '0;
            shifter      <= '0;
            words_filled <= '0;
            words_done   <= '0;
            out_valid_q  <= 1'b0;
            done         <= 1'b0;
            core_load    <= 1'b0;
        end else begin
            done      <= 1'b0;
            core_load <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            state        <= LOAD;
                            core_load    <= 1'b1;
                            len_q        <= len;
                            warm_cnt     <= '0;
                            bit_cnt      <= '0;
                            shifter      <= '0;
                            words_filled <= '0;
                            words_done   <= '0;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                LOAD: state <= WARMUP;
                WARMUP: begin
                    if (warm_cnt == WARM_LAST) begin
                        warm_cnt <= '0;
                        state    <= RUN;
                    end else begin
                        warm_cnt <= warm_cnt + WC_W'(1);
                    end
                end
                RUN: begin
                    if (hs) begin
                        out_valid_q <= 1'b0;
                        words_done  <= words_done + LEN_ONE;
                        if (words_done + LEN_ONE == len_q) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                    // A completing fill goes straight to the output register
                    // when it is free (or being emptied this cycle); otherwise
                    // the word is parked in the shifter and the core freezes.
                    if (core_step) begin
                        if (bit_cnt == BIT_LAST) begin
                            words_filled <= words_filled + LEN_ONE;
                            if (!out_valid_q || hs) begin
                                out_data_q  <= word_new;
                                out_valid_q <= 1'b1;
                                bit_cnt     <= '0;
                            end else begin
                                shifter <= word_new;
                                bit_cnt <= BIT_FULL;
                            end
                        end else begin
                            shifter <= {core_ks_bit, shifter[OUT_W-1:1]};
                            bit_cnt <= bit_cnt + BC_W'(1);
                        end
                    end else if ((bit_cnt == BIT_FULL) && hs) begin
                        out_data_q  <= shifter;
                        out_valid_q <= 1'b1;
                        bit_cnt     <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_trivium_seq_ctrl.sv
`timescale 1ns/1ps
module tb_trivium_seq_ctrl;
    localparam int OUT_W = 8;
    localparam int LEN_W = 16;
    localparam int WARM  = 1152;

    logic             clk   = 1'b0;
    logic             rst   = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [LEN_W-1:0] len   = '0;
    logic             busy, done, core_load, core_step, core_ks_bit;

    trivium_seq_ctrl_if #(.OUT_W(OUT_W)) strm();

    trivium_seq_ctrl #(
        .WARMUP_CYCLES(WARM),
        .OUT_W(OUT_W),
        .LEN_W(LEN_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .len(len),
        .abort(abort),
        .busy(busy),
        .done(done),
        .core_load(core_load),
        .core_step(core_step),
        .core_ks_bit(core_ks_bit),
        .strm(strm)
    );

    always #5 clk = ~clk;

    // Stub core: keystream bit is the LSB of the step count since load.
    logic [31:0] ks_cnt     = '0;
    logic [31:0] step_total = '0;
    logic [31:0] load_total = '0;
    always @(posedge clk) begin
        if (core_load) ks_cnt <= '0;
        else if (core_step) ks_cnt <= ks_cnt + 1;
        if (core_step) step_total <= step_total + 1;
        if (core_load) load_total <= load_total + 1;
    end
    assign core_ks_bit = ks_cnt[0];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic start_session(input int l);
        start = 1'b1;
        len   = LEN_W'(l);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!strm.out_valid && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) check("valid_timeout", 32'(0), 32'(1));
    endtask

    logic [7:0] wdata [8];
    int         widx  [8];
    int         nw;
    int         done_at;

    task automatic collect(input int bound);
        nw = 0;
        done_at = -1;
        for (int c = 0; c < bound; c++) begin
            if (done) begin
                done_at = c;
                break;
            end
            if (strm.out_valid && strm.out_ready && nw < 8) begin
                wdata[nw] = strm.out_data;
                widx[nw]  = c;
                nw++;
            end
            tick();
        end
    endtask

    int          n;
    logic [31:0] sb, lb, s0;
    logic [7:0]  d0;
    logic        flag;
`ifdef TRIV_CIPHER_EN
    localparam logic [7:0] EXP_WORD = 8'h55;
`else
    localparam logic [7:0] EXP_WORD = 8'hAA;
`endif

    initial begin
        strm.out_ready = 1'b1;
`ifdef TRIV_CIPHER_EN
        strm.in_data  = 8'hFF;
        strm.in_valid = 1'b1;
`endif
        // reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_busy",  32'(busy), 0);
        check("rst_done",  32'(done), 0);
        check("rst_load",  32'(core_load), 0);
        check("rst_step",  32'(core_step), 0);
        check("rst_valid", 32'(strm.out_valid), 0);
        check("rst_data",  32'(strm.out_data), 0);
        rst = 1'b1;
        tick();

        // single word, consumer always ready
        sb = step_total;
        lb = load_total;
        start_session(1);
        check("t2_load", 32'(core_load), 1);
        check("t2_busy", 32'(busy), 1);
        wait_valid(n);
        check("t2_latency", 32'(n), 1161);
        check("t2_steps", step_total - sb, 1160);
        check("t2_data", 32'(strm.out_data), 32'(EXP_WORD));
        collect(20);
        check("t2_words", 32'(nw), 1);
        check("t2_done_at", 32'(done_at), 1);
        check("t2_busy_end", 32'(busy), 0);
        check("t2_loads", load_total - lb, 1);
        tick();
        check("t2_done_pulse", 32'(done), 0);
        check("t2_steps_end", step_total - sb, 1160);

        // backpressure, three words
        strm.out_ready = 1'b0;
        sb = step_total;
        start_session(3);
        wait_valid(n);
        s0 = step_total;
        d0 = strm.out_data;
        check("t3_w0_data", 32'(d0), 32'(EXP_WORD));
        flag = 1'b1;
        repeat (20) begin
            tick();
            if (strm.out_data !== d0 || !strm.out_valid) flag = 1'b0;
        end
        check("t3_stable", 32'(flag), 1);
        check("t3_stall_steps", step_total - s0, 8);
        check("t3_step_frozen", 32'(core_step), 0);
        strm.out_ready = 1'b1;
        collect(100);
        check("t3_words", 32'(nw), 3);
        for (int i = 0; i < 3; i++) check("t3_data", 32'(wdata[i]), 32'(EXP_WORD));
        check("t3_no_bubble", 32'(widx[1] - widx[0]), 1);
        check("t3_done_at", 32'(done_at - widx[2]), 1);
        check("t3_total_steps", step_total - sb, 1152 + 24);
        tick();

        // zero-length request
        lb = load_total;
        start_session(0);
        check("t4_done", 32'(done), 1);
        check("t4_busy", 32'(busy), 0);
        tick();
        check("t4_done_pulse", 32'(done), 0);
        check("t4_loads", load_total - lb, 0);

        // abort during warm-up, then a clean session
        sb = step_total;
        start_session(1);
        n = 0;
        while (step_total - sb != 500 && n < 2000) begin
            tick();
            n++;
        end
        check("t5_reach_500", 32'(n < 2000), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_busy", 32'(busy), 0);
        check("t5_step", 32'(core_step), 0);
        check("t5_valid", 32'(strm.out_valid), 0);
        flag = 1'b0;
        repeat (10) begin
            if (done) flag = 1'b1;
            tick();
        end
        check("t5_no_done", 32'(flag), 0);
        sb = step_total;
        start_session(1);
        wait_valid(n);
        check("t5_latency", 32'(n), 1161);
        check("t5_steps", step_total - sb, 1160);
        check("t5_data", 32'(strm.out_data), 32'(EXP_WORD));
        collect(20);
        check("t5_done_at", 32'(done_at), 1);
        tick();

        // asynchronous reset mid-RUN
        strm.out_ready = 1'b0;
        start_session(4);
        wait_valid(n);
        rst = 1'b0;
        #1;
        check("t1_valid", 32'(strm.out_valid), 0);
        check("t1_data",  32'(strm.out_data), 0);
        check("t1_busy",  32'(busy), 0);
        check("t1_step",  32'(core_step), 0);
        check("t1_load",  32'(core_load), 0);
        check("t1_done",  32'(done), 0);
        #1;
        rst = 1'b1;
        strm.out_ready = 1'b1;
        lb = load_total;
        flag = 1'b0;
        repeat (10) begin
            tick();
            if (busy) flag = 1'b1;
        end
        check("t1_idle", 32'(flag), 0);
        check("t1_no_load", load_total - lb, 0);

`ifdef TRIV_CIPHER_EN
        // cipher: two words, then an in_valid stall
        start_session(2);
        wait_valid(n);
        collect(100);
        check("t6_words", 32'(nw), 2);
        check("t6_w0", 32'(wdata[0]), 32'h55);
        check("t6_w1", 32'(wdata[1]), 32'h55);
        tick();
        sb = step_total;
        start_session(1);
        n = 0;
        while (step_total - sb != 1155 && n < 2000) begin
            tick();
            n++;
        end
        strm.in_valid = 1'b0;
        tick();
        s0 = step_total;
        repeat (5) tick();
        check("t6_stall_steps", step_total - s0, 0);
        check("t6_stall_step", 32'(core_step), 0);
        check("t6_stall_ready", 32'(strm.in_ready), 0);
        strm.in_valid = 1'b1;
        wait_valid(n);
        check("t6_stall_data", 32'(strm.out_data), 32'h55);
        collect(20);
        check("t6_done_at", 32'(done_at), 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
